// File: rtl/alu_result_buf.sv
// Two-entry elastic FIFO between the ktc32 ALU and writeback, with flush.
// Define ALU_RESULT_BUF_FWD_EN to add the youngest-entry forwarding tap.
module alu_result_buf #(
   parameter int unsigned RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        res_in,
   input  logic               zero_in,
   input  logic [RADDR_W-1:0] rd_in,
   input  logic               wen_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        res_out,
   output logic               zero_out,
   output logic [RADDR_W-1:0] rd_out,
   output logic               wen_out
`ifdef ALU_RESULT_BUF_FWD_EN
   ,
   output logic               fwd_valid,
   output logic [RADDR_W-1:0] fwd_rd,
   output logic [31:0]        fwd_data
`endif
);

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned DEPTH   = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t               state;
   logic                 head;
   logic [DATA_W-1:0]    res_q  [DEPTH];
   logic                 zero_q [DEPTH];
   logic [RADDR_W-1:0]   rd_q   [DEPTH];
   logic                 wen_q  [DEPTH];

   logic push;
   logic pop;
   logic wr_idx;

   assign push   = in_valid & in_ready & ~flush;
   assign pop    = out_valid & out_ready & ~flush;
   // An empty buffer writes at head; otherwise the free slot is the other one.
   assign wr_idx = (state == EMPTY) ? head : ~head;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= EMPTY;
         head      <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         for (int i = 0; i < int'(DEPTH); i++) begin
            res_q[i]  <= '0;
            zero_q[i] <= 1'b0;
            rd_q[i]   <= '0;
            wen_q[i]  <= 1'b0;
         end
      end else begin
         if (push) begin
            res_q[wr_idx]  <= res_in;
            zero_q[wr_idx] <= zero_in;
            rd_q[wr_idx]   <= rd_in;
            wen_q[wr_idx]  <= wen_in;
         end

         if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
         end else begin
            case (state)
               EMPTY: begin
                  if (push) begin
                     state     <= ONE;
                     out_valid <= 1'b1;
                  end
               end
               ONE: begin
                  if (push && !pop) begin
                     state    <= FULL;
                     in_ready <= 1'b0;
                  end else if (pop && !push) begin
                     state     <= EMPTY;
                     out_valid <= 1'b0;
                     head      <= ~head;
                  end else if (pop && push) begin
                     head <= ~head;
                  end
               end
               FULL: begin
                  if (pop) begin
                     state    <= ONE;
                     in_ready <= 1'b1;
                     head     <= ~head;
                  end
               end
               default: begin
                  state     <= EMPTY;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            endcase
         end
      end
   end

   assign res_out  = res_q[head];
   assign zero_out = zero_q[head];
   assign rd_out   = rd_q[head];
   assign wen_out  = wen_q[head];

`ifdef ALU_RESULT_BUF_FWD_EN
   logic young_idx;
   logic fwd_hit;

   // Youngest entry is the tail when full, the head when holding one.
   assign young_idx = (state == FULL) ? ~head : head;
   assign fwd_hit   = (state != EMPTY) & wen_q[young_idx] & (rd_q[young_idx] != '0);
   assign fwd_valid = fwd_hit;
   assign fwd_rd    = fwd_hit ? rd_q[young_idx]  : '0;
   assign fwd_data  = fwd_hit ? res_q[young_idx] : '0;
`endif

endmodule

// File: tb/tb_alu_result_buf.sv
// Scoreboard bench for alu_result_buf: directed pushes queue expectations,
// a negedge monitor retires them against the DUT head on every pop.
module tb_alu_result_buf;

   localparam int unsigned RADDR_W = 5;

   typedef struct packed {
      logic [31:0]        res;
      logic               zero;
      logic [RADDR_W-1:0] rd;
      logic               wen;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               flush;
   logic               in_valid;
   logic               in_ready;
   logic [31:0]        res_in;
   logic               zero_in;
   logic [RADDR_W-1:0] rd_in;
   logic               wen_in;
   logic               out_valid;
   logic               out_ready;
   logic [31:0]        res_out;
   logic               zero_out;
   logic [RADDR_W-1:0] rd_out;
   logic               wen_out;
`ifdef ALU_RESULT_BUF_FWD_EN
   logic               fwd_valid;
   logic [RADDR_W-1:0] fwd_rd;
   logic [31:0]        fwd_data;
`endif

   int vectors     = 0;
   int miscompares = 0;
   exp_t exp_q[$];

   alu_result_buf #(.RADDR_W(RADDR_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .res_in(res_in), .zero_in(zero_in), .rd_in(rd_in), .wen_in(wen_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .res_out(res_out), .zero_out(zero_out), .rd_out(rd_out), .wen_out(wen_out)
`ifdef ALU_RESULT_BUF_FWD_EN
      , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] r, input logic z,
                        input logic [RADDR_W-1:0] d, input logic w);
      in_valid = v;
      res_in   = r;
      zero_in  = z;
      rd_in    = d;
      wen_in   = w;
   endtask

   task automatic expect_push(input logic [31:0] r, input logic z,
                              input logic [RADDR_W-1:0] d, input logic w);
      exp_t e;
      e.res  = r;
      e.zero = z;
      e.rd   = d;
      e.wen  = w;
      exp_q.push_back(e);
   endtask

   task automatic chk_fwd(input string name, input logic v, input logic [RADDR_W-1:0] d,
                          input logic [31:0] r);
`ifdef ALU_RESULT_BUF_FWD_EN
      chk({name, "_fwd_valid"}, 32'(fwd_valid), 32'(v));
      chk({name, "_fwd_rd"},    32'(fwd_rd),    32'(d));
      chk({name, "_fwd_data"},  fwd_data,       r);
`else
      if (name.len() < 0) $display("%0d %0d %0d", v, d, r);
`endif
   endtask

   // Retire monitor: every real pop must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready && !flush) begin
         exp_t act;
         exp_t e;
         act = {res_out, zero_out, rd_out, wen_out};
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL retire_unexpected: got %h expected none", act);
         end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
               miscompares++;
               $display("FAIL retire: got %h expected %h", act, e);
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 32'h0, 1'b0, '0, 1'b0);
      step();
      step();
      rst = 1'b0;

      // Reset / idle state
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_res_out",   res_out,        32'd0);
      chk("rst_zero_out",  32'(zero_out),  32'd0);
      chk("rst_rd_out",    32'(rd_out),    32'd0);
      chk("rst_wen_out",   32'(wen_out),   32'd0);
      chk_fwd("rst", 1'b0, '0, 32'd0);

      // Single push with writeback ready
      step();
      out_ready = 1'b1;
      drive(1'b1, 32'h0000_0005, 1'b0, 5'd3, 1'b1);
      expect_push(32'h0000_0005, 1'b0, 5'd3, 1'b1);
      step();
      drive(1'b0, 32'h0, 1'b0, '0, 1'b0);
      @(negedge clk);
      chk("single_out_valid", 32'(out_valid), 32'd1);
      chk("single_res_out",   res_out,        32'h5);
      chk("single_rd_out",    32'(rd_out),    32'd3);
      step();
      @(negedge clk);
      chk("single_empty", 32'(out_valid), 32'd0);

      // Fill to FULL under backpressure, third input refused
      step();
      out_ready = 1'b0;
      drive(1'b1, 32'h0000_0000, 1'b1, 5'd1, 1'b1);
      expect_push(32'h0000_0000, 1'b1, 5'd1, 1'b1);
      step();
      drive(1'b1, 32'h0001_0000, 1'b0, 5'd2, 1'b0);
      @(negedge clk);
      chk("fill_in_ready_one", 32'(in_ready), 32'd1);
      chk_fwd("fill_one", 1'b1, 5'd1, 32'h0);
      expect_push(32'h0001_0000, 1'b0, 5'd2, 1'b0);
      step();
      drive(1'b1, 32'h0000_0BAD, 1'b0, 5'd9, 1'b1);
      @(negedge clk);
      chk("full_in_ready",  32'(in_ready),  32'd0);
      chk("full_out_valid", 32'(out_valid), 32'd1);
      chk("full_zero_out",  32'(zero_out),  32'd1);
      chk_fwd("full_wen0", 1'b0, '0, 32'h0);
      step();
      @(negedge clk);
      chk("stall_res_stable",  res_out,        32'h0);
      chk("stall_in_ready",    32'(in_ready),  32'd0);
      step();
      drive(1'b0, 32'h0, 1'b0, '0, 1'b0);
      out_ready = 1'b1;
      step();
      step();
      @(negedge clk);
      chk("drain_empty", 32'(out_valid), 32'd0);

      // Sustained streaming: eight pushes, one per cycle
      for (int i = 0; i < 8; i++) begin
         step();
         drive(1'b1, 32'h0000_0100 + 32'(i), 1'b0, 5'(i + 1), 1'b1);
         @(negedge clk);
         chk("stream_in_ready", 32'(in_ready), 32'd1);
         if (i > 0) chk("stream_out_valid", 32'(out_valid), 32'd1);
         expect_push(32'h0000_0100 + 32'(i), 1'b0, 5'(i + 1), 1'b1);
      end
      step();
      drive(1'b0, 32'h0, 1'b0, '0, 1'b0);
      @(negedge clk);
      chk("stream_last_valid", 32'(out_valid), 32'd1);
      step();
      @(negedge clk);
      chk("stream_empty", 32'(out_valid), 32'd0);

      // Flush from FULL with same-cycle input and out_ready
      out_ready = 1'b0;
      drive(1'b1, 32'h0000_00D0, 1'b0, 5'd4, 1'b1);
      step();
      drive(1'b1, 32'h0000_00E0, 1'b0, 5'd5, 1'b1);
      step();
      drive(1'b1, 32'h0000_00F0, 1'b0, 5'd6, 1'b1);
      out_ready = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 1'b0, '0, 1'b0);
      @(negedge clk);
      chk("flush_full_out_valid", 32'(out_valid), 32'd0);
      chk("flush_full_in_ready",  32'(in_ready),  32'd1);

      // Flush from ONE drops an input that in_ready would have admitted
      out_ready = 1'b0;
      step();
      drive(1'b1, 32'h0000_0111, 1'b0, 5'd7, 1'b1);
      step();
      drive(1'b1, 32'h0000_0222, 1'b0, 5'd8, 1'b1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 1'b0, '0, 1'b0);
      @(negedge clk);
      chk("flush_one_out_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      drive(1'b1, 32'h0000_0333, 1'b0, 5'd10, 1'b1);
      expect_push(32'h0000_0333, 1'b0, 5'd10, 1'b1);
      step();
      drive(1'b0, 32'h0, 1'b0, '0, 1'b0);
      step();

      // Forwarding tap: youngest rd=7, then youngest rd=0
      out_ready = 1'b0;
      drive(1'b1, 32'hDEAD_BEEF, 1'b0, 5'd7, 1'b1);
      expect_push(32'hDEAD_BEEF, 1'b0, 5'd7, 1'b1);
      step();
      drive(1'b1, 32'h0000_1234, 1'b0, 5'd0, 1'b1);
      @(negedge clk);
      chk_fwd("fwd_rd7", 1'b1, 5'd7, 32'hDEAD_BEEF);
      chk("fwd_rd7_res_out", res_out, 32'hDEAD_BEEF);
      expect_push(32'h0000_1234, 1'b0, 5'd0, 1'b1);
      step();
      drive(1'b0, 32'h0, 1'b0, '0, 1'b0);
      @(negedge clk);
      chk_fwd("fwd_rd0", 1'b0, '0, 32'h0);
      chk("fwd_rd0_res_out",  res_out,       32'hDEAD_BEEF);
      chk("fwd_rd0_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      step();
      step();
      @(negedge clk);
      chk("fwd_drain_empty", 32'(out_valid), 32'd0);

      // Asynchronous reset while FULL
      out_ready = 1'b0;
      drive(1'b1, 32'h0000_0AAA, 1'b0, 5'd11, 1'b1);
      step();
      drive(1'b1, 32'h0000_0BBB, 1'b1, 5'd12, 1'b1);
      step();
      drive(1'b0, 32'h0, 1'b0, '0, 1'b0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_in_ready",  32'(in_ready),  32'd1);
      chk("arst_res_out",   res_out,        32'd0);
      chk_fwd("arst", 1'b0, '0, 32'h0);
      step();
      rst = 1'b0;
      step();

      @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
